// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-addressed register memory.
// Each OKAY transfer is stretched by WAIT_STATES cycles; out-of-range words get a two-cycle ERROR.
module ahb_slave_mem #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state, state_next;
  logic [2:0]    wait_cnt, wait_cnt_next;
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          addr_oor;
  logic [AW-1:0] addr_idx;
  logic          commit;
  logic          load_rdata;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[1:0], HTRANS[0]};

  // Only an idle or completing slot can take a new address phase.
  assign accept   = HSEL && HTRANS[1] && HREADY &&
                    (state == S_IDLE || state == S_LAST || state == S_ERR2);
  assign addr_oor = HADDR[31:2] >= 30'(DEPTH);
  assign addr_idx = HADDR[AW+1:2];
  assign commit   = (state == S_LAST) && write_q;

  // A read entering LAST on the same edge as a write commit must see the new word.
  assign rd_word  = (commit && (rd_idx == idx_q)) ? HWDATA : mem[rd_idx];

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    load_rdata    = 1'b0;
    rd_idx        = idx_q;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    case (state)
      S_IDLE, S_LAST, S_ERR2: begin
        HRESP = (state == S_ERR2);
        if (accept) begin
          if (addr_oor) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = 3'(WAIT_STATES - 1);
          end else begin
            state_next = S_LAST;
            load_rdata = !HWRITE;
            rd_idx     = addr_idx;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 3'd0) begin
          state_next = S_LAST;
          load_rdata = !write_q;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      HRDATA   <= 32'h0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        idx_q   <= addr_idx;
        write_q <= HWRITE;
      end
      if (load_rdata) begin
        HRDATA <= rd_word;
      end
    end
  end

  // Reset wins over a pending commit, so an interrupted write is lost.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (commit) begin
      mem[idx_q] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance share one clock.
// The driver queues expected completions; a negedge monitor scores each finished data phase.
module tb_ahb_slave_mem;

  localparam int DEPTH = 32;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic        resp;
    int          waits;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset    [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [1:0]  htrans    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  exp_t q0[$];
  exp_t q1[$];
  int   pending [2];
  int   low_cnt [2];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
    .HRDATA(hrdata[0])
  );

  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut_ws3 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
    .HRDATA(hrdata[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one address phase, queues its expected completion, and returns
  // just after the accepting edge with the write data placed on HWDATA.
  task automatic applyStimulus(input int k, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input logic exp_resp, input int exp_waits, input string name);
    exp_t e;
    bit   rdy;
    int   n;
    e.chk_data = !wr && !exp_resp;
    e.data     = exp_data;
    e.resp     = exp_resp;
    e.waits    = exp_waits;
    e.name     = name;
    hsel[k]    = 1'b1;
    htrans[k]  = 2'b10;
    haddr[k]   = addr;
    hwrite[k]  = wr;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = (hreadyout[k] === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      $display("[TB] FAIL %s_accept: HREADYOUT stayed 0 for %0d cycles, required 1", name, n);
    end
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
    hwrite[k] = 1'b0;
    hwdata[k] = wdata;
  endtask

  // BUSY with HSEL=1, then NONSEQ with HSEL=0; neither may be taken.
  task automatic filter_test(input int k, input logic [31:0] addr);
    hsel[k]   = 1'b1;
    htrans[k] = 2'b01;
    haddr[k]  = addr;
    hwrite[k] = 1'b1;
    idle_cycles(1);
    hwdata[k] = 32'hFFFF_FFFF;
    hsel[k]   = 1'b0;
    htrans[k] = 2'b10;
    idle_cycles(1);
    hwdata[k] = 32'hEEEE_EEEE;
    htrans[k] = 2'b00;
    hwrite[k] = 1'b0;
    haddr[k]  = 32'h0;
    idle_cycles(1);
  endtask

  task automatic monitor_step(input int k);
    exp_t e;
    int   depth;
    if (!mon_en) return;
    if (hreset[k]) begin
      pending[k] = 0;
      low_cnt[k] = 0;
      if (k == 0) q0.delete();
      else q1.delete();
      return;
    end
    depth = (k == 0) ? q0.size() : q1.size();
    if (pending[k] != 0) begin
      if (depth == 0) begin
        checks++;
        $display("[TB] FAIL dut%0d_scoreboard: completion with empty queue, required an entry", k);
        pending[k] = 0;
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        if (hreadyout[k] !== 1'b1) begin
          low_cnt[k]++;
          checkOutput({e.name, "_resp_stall"}, 32'(hresp[k]), 32'(e.resp));
          if (low_cnt[k] > 20) begin
            checks++;
            $display("[TB] FAIL %s_timeout: %0d stall cycles, required %0d", e.name, low_cnt[k], e.waits);
            if (k == 0) e = q0.pop_front();
            else e = q1.pop_front();
            pending[k] = 0;
            low_cnt[k] = 0;
          end
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          checkOutput({e.name, "_waits"}, 32'(low_cnt[k]), 32'(e.waits));
          checkOutput({e.name, "_resp"}, 32'(hresp[k]), 32'(e.resp));
          if (e.chk_data) checkOutput({e.name, "_rdata"}, hrdata[k], e.data);
          pending[k] = 0;
          low_cnt[k] = 0;
        end
      end
    end else begin
      checkOutput($sformatf("dut%0d_idle_ready", k), 32'(hreadyout[k]), 32'd1);
      checkOutput($sformatf("dut%0d_idle_resp", k), 32'(hresp[k]), 32'd0);
    end
    if (hsel[k] && htrans[k][1] && hreadyout[k]) pending[k] = 1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) monitor_step(k);
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      hreset[k]  = 1'b1;
      hsel[k]    = 1'b0;
      haddr[k]   = 32'h0;
      hwrite[k]  = 1'b0;
      htrans[k]  = 2'b00;
      hwdata[k]  = 32'h0;
      pending[k] = 0;
      low_cnt[k] = 0;
    end
    idle_cycles(2);
    hreset[0] = 1'b0;
    hreset[1] = 1'b0;
    mon_en    = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d_rst_ready", k), 32'(hreadyout[k]), 32'd1);
      checkOutput($sformatf("dut%0d_rst_resp", k), 32'(hresp[k]), 32'd0);
      checkOutput($sformatf("dut%0d_rst_rdata", k), hrdata[k], 32'h0);
    end
    @(posedge clk);
    #1;

    // Zero-wait instance
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 0, "ws0_rst_read5");
    applyStimulus(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "ws0_wr14");
    idle_cycles(1);
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "ws0_rd14");
    idle_cycles(1);
    applyStimulus(0, 1'b1, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 0, "ws0_fwd_wr");
    applyStimulus(0, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 0, "ws0_fwd_rd");
    applyStimulus(0, 1'b1, 32'h7C, 32'hA5A5_0001, 32'h0, 1'b0, 0, "ws0_wr_top");
    applyStimulus(0, 1'b1, 32'h00, 32'h0000_00FF, 32'h0, 1'b0, 0, "ws0_wr0");
    applyStimulus(0, 1'b0, 32'h7F, 32'h0, 32'hA5A5_0001, 1'b0, 0, "ws0_rd_top_lsb");
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 32'h0000_00FF, 1'b0, 0, "ws0_rd0");
    applyStimulus(0, 1'b1, 32'h80, 32'hBAD0_0000, 32'h0, 1'b1, 1, "ws0_err_wr");
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 32'h0000_00FF, 1'b0, 0, "ws0_rd0_after_err");
    applyStimulus(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1, "ws0_err_rd");
    idle_cycles(2);
    filter_test(0, 32'h14);
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "ws0_rd14_filtered");
    idle_cycles(1);

    // Three-wait instance
    applyStimulus(1, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 3, "ws3_rst_read5");
    applyStimulus(1, 1'b1, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0, 3, "ws3_wr0");
    repeat (4) begin
      @(negedge clk);
      checkOutput("ws3_mem0_hold", dut_ws3.mem[0], 32'h0);
    end
    @(negedge clk);
    checkOutput("ws3_mem0_commit", dut_ws3.mem[0], 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0, 3, "ws3_rd0");
    applyStimulus(1, 1'b1, 32'h80, 32'h1111_2222, 32'h0, 1'b1, 1, "ws3_err_wr");
    applyStimulus(1, 1'b0, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0, 3, "ws3_rd0_after_err");
    applyStimulus(1, 1'b1, 32'h08, 32'h0000_0011, 32'h0, 1'b0, 3, "ws3_wr8");
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 32'h0000_0011, 1'b0, 3, "ws3_rd8");
    idle_cycles(1);
    filter_test(1, 32'h08);
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 32'h0000_0011, 1'b0, 3, "ws3_rd8_filtered");
    idle_cycles(1);
    applyStimulus(1, 1'b1, 32'h10, 32'h5555_AAAA, 32'h0, 1'b0, 3, "ws3_wr_dropped");
    idle_cycles(1);
    hreset[1] = 1'b1;
    idle_cycles(1);
    hreset[1] = 1'b0;
    @(negedge clk);
    checkOutput("ws3_midrst_ready", 32'(hreadyout[1]), 32'd1);
    checkOutput("ws3_midrst_resp", 32'(hresp[1]), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 3, "ws3_rd_dropped");
    applyStimulus(1, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 3, "ws3_rd0_after_rst");
    idle_cycles(6);

    checkOutput("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder holding a word-addressed register memory, the completion side for the team's AHB master. Samples address-phase controls, inserts a configurable number of wait states, performs the write or returns read data in the data phase, and signals a two-cycle ERROR for out-of-range addresses. Sits on the bus behind the decoder's HSEL and returns HREADYOUT, HRESP and HRDATA.

## Interface

- DEPTH, 32: number of 32-bit words; legal word index range is 0..DEPTH-1. Must be a power of two, 2..1024.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted before each OKAY completion; legal range 0..7.
- HCLK  in  1  bus clock; everything is updated on the rising edge.
- HRESET  in  1  one clock; reset is synchronous and active-high.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address; the word index is HADDR[31:2]. HADDR[1:0] is ignored.
- HWRITE  in  1  1 = write, 0 = read; sampled in the address phase.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; a new address phase is accepted only when it is high.
- HREADYOUT  out  1  slave ready; low extends the current data phase.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data; valid only while HREADYOUT=1 in the final cycle of a read data phase.

## Operation

- Accept condition: a transfer is accepted when, at a rising edge, HSEL=1, HTRANS[1]=1 and HREADY=1. IDLE and BUSY are never accepted and get a zero-wait OKAY.
- On accept, the slave registers the word index, HWRITE, and an out-of-range flag. The flag is set when HADDR[31:2] is greater than or equal to DEPTH.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0; a counter runs from WAIT_STATES-1 down to 0.
  - LAST: HREADYOUT=1, HRESP=0; the data phase completes here.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on accept, evaluated from IDLE, LAST or ERR2:
  - out-of-range goes to ERR1;
  - otherwise, if WAIT_STATES>0, go to WAIT;
  - otherwise go to LAST.
- Other transitions:
  - WAIT goes to LAST when the counter is 0.
  - ERR1 always goes to ERR2.
  - LAST or ERR2 with no new accept goes to IDLE.
- Accepts are sampled only when HREADY=1, so no new address is taken while in WAIT or ERR1.
- Write: mem[idx] <= HWDATA at the rising edge that ends LAST. An ERROR transfer never writes.
- Read: HRDATA is registered. It loads mem[idx] on the edge that enters LAST, and it holds its value in all other states.
- Read-after-write forwarding: a read accepted at the same edge that commits a write to the same index loads HWDATA, not the stale memory word.
- An accept that arrives while ERR2 completes is honoured normally. The master is expected to cancel it, but the slave does not require that.

## Timing

- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, all memory words 0.
- Reset has priority over every state. In-flight transfers are dropped and no write occurs during the reset cycle.
- Zero-wait pipelining (WAIT_STATES=0): back-to-back NONSEQ/SEQ transfers complete one per cycle with HREADYOUT held at 1.
- Latency, accept edge to completing edge:
  - OKAY transfer: WAIT_STATES+1 cycles.
  - ERROR transfer: always 2 cycles, with no wait states added.
- HRESP=1 appears one cycle before HREADYOUT returns to 1, as AHB requires.

## Test plan

- Reset: assert HRESET for 2 cycles, then read index 5 -> HRDATA=0x00000000, HRESP=0, and HREADYOUT=1 after reset.
- Single write then read, WAIT_STATES=0: write 0xDEADBEEF to HADDR 0x14, then read 0x14 -> HRDATA=0xDEADBEEF one cycle after the read address phase.
- Back-to-back forwarding: NONSEQ write 0x12345678 to 0x08 immediately followed by a read of 0x08 -> read returns 0x12345678 with no stall.
- Wait states (WAIT_STATES=3): write to 0x00 -> HREADYOUT low for exactly 3 cycles; memory is unchanged until the edge ending LAST.
- Error: with DEPTH=32, write to 0x80 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, and no memory word changes.
- Mid-transfer reset and filtering:
  - pulse HRESET in the 2nd WAIT cycle -> next cycle HREADYOUT=1, HRESP=0, write discarded;
  - HTRANS=BUSY or HSEL=0 -> no state change and no write.
